// File: rtl/usb_rx_crc_check_if.sv
// rtl/usb_rx_crc_check_if.sv - byte-stream and verdict signals of the USB receive packet checker
interface usb_rx_crc_check_if #(
  parameter int LEN_W = 11
);
  logic             rx_active;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic [7:0]       data_out;
  logic             data_valid;
  logic [3:0]       pid;
  logic [LEN_W-1:0] pkt_len;
  logic             pkt_ok;
  logic             pkt_err;

  modport master (
    output rx_active, rx_valid, rx_data,
    input  rx_ready, data_out, data_valid, pid, pkt_len, pkt_ok, pkt_err
  );

  modport slave (
    input  rx_active, rx_valid, rx_data,
    output rx_ready, data_out, data_valid, pid, pkt_len, pkt_ok, pkt_err
  );
endinterface

// File: rtl/usb_rx_crc_check.sv
// rtl/usb_rx_crc_check.sv - USB receive checker: PID/CRC16 validation, CRC byte stripping, verdict pulse
// Defining USB_RX_PID_CHECK_EN enables the PID nibble-complement check.
module usb_rx_crc_check #(
  parameter int MAX_LEN = 1024,
  parameter int LEN_W   = 11
) (
  input  logic              clk,
  input  logic              reset,
  usb_rx_crc_check_if.slave bus
);
  localparam int               CNT_W        = LEN_W + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT    = CNT_W'(MAX_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_TWO      = CNT_W'(2);
  localparam logic [15:0]      CRC_INIT     = 16'hFFFF;
  localparam logic [15:0]      CRC_RESIDUAL = 16'hB001;

  typedef enum logic [2:0] {SYNC, IDLE, DATA, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [15:0]      crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [7:0]       hold0_q, hold0_d;
  logic [7:0]       hold1_q, hold1_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic [3:0]       pid_q, pid_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ok_q, ok_d;
  logic             bad_q, bad_d;

  logic             rx_ready;
  logic             accept;
  logic             pid_pass;
  logic             verdict_pass;
  logic [LEN_W-1:0] verdict_len;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

`ifdef USB_RX_PID_CHECK_EN
  assign pid_pass = (bus.rx_data[7:4] == ~bus.rx_data[3:0]);
`else
  assign pid_pass = 1'b1;
`endif

  assign rx_ready     = (state_q == IDLE) || (state_q == DATA) || (state_q == DRAIN);
  assign accept       = bus.rx_valid && rx_ready && bus.rx_active;
  assign verdict_pass = !err_q && (cnt_q >= CNT_TWO) && (crc_q == CRC_RESIDUAL);
  assign verdict_len  = (cnt_q >= CNT_TWO) ? LEN_W'(cnt_q - CNT_TWO) : '0;

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    hold0_d      = hold0_q;
    hold1_d      = hold1_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    pid_d        = pid_q;
    len_d        = len_q;
    ok_d         = 1'b0;
    bad_d        = 1'b0;
    case (state_q)
      SYNC: begin
        if (!bus.rx_active) state_d = IDLE;
      end
      IDLE: begin
        if (accept) begin
          pid_d   = bus.rx_data[3:0];
          crc_d   = CRC_INIT;
          cnt_d   = '0;
          err_d   = !pid_pass;
          state_d = pid_pass ? DATA : DRAIN;
        end
      end
      DATA: begin
        if (!bus.rx_active) begin
          state_d = DONE;
          ok_d    = verdict_pass;
          bad_d   = !verdict_pass;
          len_d   = verdict_len;
        end else if (accept) begin
          if (cnt_q == CNT_LIMIT) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            // Two-byte holdoff: the newest two bytes may be the CRC, so only older ones leave.
            crc_d   = crc16_byte(crc_q, bus.rx_data);
            cnt_d   = cnt_q + CNT_W'(1);
            hold0_d = hold1_q;
            hold1_d = bus.rx_data;
            if (cnt_q >= CNT_TWO) begin
              data_valid_d = 1'b1;
              data_out_d   = hold0_q;
            end
          end
        end
      end
      DRAIN: begin
        if (!bus.rx_active) begin
          state_d = DONE;
          ok_d    = verdict_pass;
          bad_d   = !verdict_pass;
          len_d   = verdict_len;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = SYNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= SYNC;
      crc_q        <= CRC_INIT;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      hold0_q      <= '0;
      hold1_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      pid_q        <= '0;
      len_q        <= '0;
      ok_q         <= 1'b0;
      bad_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      hold0_q      <= hold0_d;
      hold1_q      <= hold1_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      pid_q        <= pid_d;
      len_q        <= len_d;
      ok_q         <= ok_d;
      bad_q        <= bad_d;
    end
  end

  assign bus.rx_ready   = rx_ready;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.pid        = pid_q;
  assign bus.pkt_len    = len_q;
  assign bus.pkt_ok     = ok_q;
  assign bus.pkt_err    = bad_q;
endmodule

// File: tb/tb_usb_rx_crc_check.sv
// tb/tb_usb_rx_crc_check.sv - scoreboard bench for usb_rx_crc_check with a packet-level reference model
module tb_usb_rx_crc_check;
  localparam int MAX_LEN = 24;
  localparam int LEN_W   = 5;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic       ok;
    logic [3:0] pid;
    int         len;
    logic       chk_len;
  } verdict_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  usb_rx_crc_check_if #(.LEN_W(LEN_W)) bus ();

  usb_rx_crc_check #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] exp_data[$];
  verdict_t   exp_verd[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // USB CRC16 computed bit-serially from the polynomial definition.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ 16'hA001;
    end
    return r;
  endfunction

  function automatic bit pid_good(input logic [7:0] p);
`ifdef USB_RX_PID_CHECK_EN
    return p[7:4] == ~p[3:0];
`else
    return 1'b1;
`endif
  endfunction

  function automatic bq_t with_crc(input logic [7:0] pid, input bq_t pl, input bit flip);
    bq_t         q;
    logic [15:0] c;
    c = 16'hFFFF;
    q.push_back(pid);
    foreach (pl[i]) begin
      c = crc_upd(c, pl[i]);
      q.push_back(pl[i]);
    end
    c = ~c;
    q.push_back(c[7:0]);
    q.push_back(c[15:8] ^ (flip ? 8'h01 : 8'h00));
    return q;
  endfunction

  task automatic expect_pkt(input bq_t q);
    verdict_t    v;
    logic [15:0] c;
    logic [7:0]  p;
    int          m;
    m         = q.size() - 1;
    p         = q[0];
    v.pid     = p[3:0];
    v.len     = 0;
    v.chk_len = 1'b1;
    v.ok      = 1'b0;
    if (pid_good(p)) begin
      if (m > MAX_LEN + 2) begin
        for (int i = 1; i <= MAX_LEN; i++) exp_data.push_back(q[i]);
        v.chk_len = 1'b0;
      end else begin
        for (int i = 1; i <= m - 2; i++) exp_data.push_back(q[i]);
        c = 16'hFFFF;
        for (int i = 1; i <= m; i++) c = crc_upd(c, q[i]);
        v.ok  = (m >= 2) && (c == 16'hB001);
        v.len = (m >= 2) ? m - 2 : 0;
      end
    end
    exp_verd.push_back(v);
  endtask

  task automatic drive_byte(input logic [7:0] b);
    int t;
    if ($urandom_range(3) == 0) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    t = 0;
    while (!bus.rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("ready_timeout", 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input bq_t q);
    int t;
    expect_pkt(q);
    @(negedge clk);
    bus.rx_active = 1'b1;
    foreach (q[i]) drive_byte(q[i]);
    bus.rx_active = 1'b0;
    bus.rx_valid  = 1'($urandom_range(1));
    bus.rx_data   = 8'($urandom);
    t = 0;
    while (exp_verd.size() != 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    bus.rx_valid = 1'b0;
    check("verdict_seen", 32'(exp_verd.size()), 32'd0);
    check("strobes_drained", 32'(exp_data.size()), 32'd0);
    repeat ($urandom_range(2)) @(negedge clk);
  endtask

  task automatic reset_mid_packet();
    bq_t pl;
    for (int i = 0; i < 5; i++) pl.push_back(8'($urandom));
    for (int i = 0; i < 3; i++) exp_data.push_back(pl[i]);
    @(negedge clk);
    bus.rx_active = 1'b1;
    drive_byte(8'hC3);
    foreach (pl[i]) drive_byte(pl[i]);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst_data_valid", 32'(bus.data_valid), 32'd0);
    check("rst_pkt_ok", 32'(bus.pkt_ok), 32'd0);
    check("rst_pkt_err", 32'(bus.pkt_err), 32'd0);
    check("rst_strobes", 32'(exp_data.size()), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
      check("sync_rx_ready", 32'(bus.rx_ready), 32'd0);
    end
    bus.rx_valid  = 1'b0;
    bus.rx_active = 1'b0;
    repeat (3) @(negedge clk);
    check("no_verdict_after_reset", 32'(bus.pkt_ok | bus.pkt_err), 32'd0);
  endtask

  always @(negedge clk) begin
    verdict_t v;
    if (bus.pkt_ok || bus.pkt_err) begin
      check("ok_err_exclusive", 32'(bus.pkt_ok & bus.pkt_err), 32'd0);
      if (exp_verd.size() == 0) begin
        check("unexpected_verdict", 32'(bus.pkt_ok | bus.pkt_err), 32'd0);
      end else begin
        v = exp_verd.pop_front();
        check("pkt_ok", 32'(bus.pkt_ok), 32'(v.ok));
        check("pkt_err", 32'(bus.pkt_err), 32'(!v.ok));
        check("pid", 32'(bus.pid), 32'(v.pid));
        if (v.chk_len) check("pkt_len", 32'(bus.pkt_len), 32'(v.len));
      end
    end
    if (bus.data_valid) begin
      if (exp_data.size() == 0) check("unexpected_strobe", 32'(bus.data_valid), 32'd0);
      else check("data_out", 32'(bus.data_out), 32'(exp_data.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t pkt;
    bq_t pl;
    logic [3:0] n;
    bus.rx_active = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("reset_data_valid", 32'(bus.data_valid), 32'd0);
    check("reset_pkt_ok", 32'(bus.pkt_ok), 32'd0);
    check("reset_pkt_err", 32'(bus.pkt_err), 32'd0);
    check("reset_pid", 32'(bus.pid), 32'd0);
    check("reset_pkt_len", 32'(bus.pkt_len), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    pkt = {8'hC3, 8'h00, 8'h00};
    send_pkt(pkt);

    pl = {8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(with_crc(8'hC3, pl, 1'b0));
    send_pkt(with_crc(8'hC3, pl, 1'b1));
    send_pkt(with_crc(8'hC4, pl, 1'b0));

    pl = {};
    for (int i = 0; i < MAX_LEN + 1; i++) pl.push_back(8'($urandom));
    send_pkt(with_crc(8'h4B, pl, 1'b0));
    void'(pl.pop_back());
    send_pkt(with_crc(8'h4B, pl, 1'b0));

    pkt = {8'hD2};
    send_pkt(pkt);
    pkt = {8'hD2, 8'h55};
    send_pkt(pkt);

    reset_mid_packet();
    pl = {8'hA5, 8'h5A};
    send_pkt(with_crc(8'hE1, pl, 1'b0));

    for (int k = 0; k < 40; k++) begin
      pl = {};
      for (int i = 0; i < int'($urandom_range(MAX_LEN + 2)); i++) pl.push_back(8'($urandom));
      n = 4'($urandom);
      if ($urandom_range(9) == 0) pkt = with_crc(8'($urandom), pl, $urandom_range(3) == 0);
      else pkt = with_crc({~n, n}, pl, $urandom_range(3) == 0);
      send_pkt(pkt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/usb_rx_crc_check.md
# usb_rx_crc_check

Receive-side packet checker for the USB test datapath: the consuming end of the `tx_valid`/`tx_ready` byte stream. It accepts the byte stream of one packet, validates the PID and the CRC16, and forwards payload bytes with the two CRC bytes stripped. At end of packet it reports a single-cycle ok/error verdict with the PID and payload length. It sits between the PHY-side byte interface and the test-bench/scoreboard logic.

## Interface
- `MAX_LEN`, 1024: maximum payload bytes, excluding PID and CRC.
- `LEN_W`, 11: width of `pkt_len`; must satisfy 2^LEN_W > MAX_LEN.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `rx_active`  in  1  high for the duration of one packet.
- `rx_valid`  in  1  `rx_data` holds a byte this cycle.
- `rx_data`  in  8  received byte.
- `rx_ready`  out  1  byte accepted when `rx_valid & rx_ready & rx_active`.
- `data_out`  out  8  forwarded payload byte.
- `data_valid`  out  1  one-cycle strobe per forwarded byte.
- `pid`  out  4  low nibble of the last captured PID byte.
- `pkt_len`  out  LEN_W  payload byte count of the last packet.
- `pkt_ok`  out  1  one-cycle pulse: packet good.
- `pkt_err`  out  1  one-cycle pulse: packet bad.

## Operation
- States: SYNC, IDLE, DATA, DRAIN, DONE.
- Reset: state SYNC. All outputs 0. CRC register 0xFFFF. Counters and holdoff cleared.
- SYNC: `rx_ready`=0. Go to IDLE when `rx_active`=0. No verdict is issued. This discards any packet cut by reset.
- IDLE: `rx_ready`=1. The first accepted byte is the PID. `pid` is updated. CRC is set to 0xFFFF and the byte counter to 0.
  - PID check passes: go to DATA.
  - PID check fails: go to DRAIN with the error flag set.
- DATA: `rx_ready`=1. Each accepted byte does the following:
  - Updates the CRC: reflected poly 0xA001, LSB first, 8 steps per byte.
  - Increments the byte counter.
  - Enters a 2-byte holdoff. When the holdoff already holds 2 bytes, its oldest byte is emitted on `data_out` with `data_valid`.
  - If the counter would exceed MAX_LEN+2: go to DRAIN with the error flag set.
- DATA with `rx_active`=0 sampled: go to DONE.
- DRAIN: `rx_ready`=1. Bytes are accepted and discarded; nothing is forwarded. Go to DONE when `rx_active`=0.
- DONE (one cycle): `rx_ready`=0. Verdict, then go to IDLE.
  - `pkt_ok` when all hold: the error flag is clear, byte count ≥ 2, and CRC = 0xB001 (USB residual).
  - `pkt_err` otherwise.
  - `pkt_len` = byte count − 2, saturating at 0. It holds until the next DONE.
- Holdoff contents are never emitted, so the CRC bytes are not forwarded.
- `rx_valid` while `rx_active`=0: the byte is ignored and not accepted.
- `rx_active` falling in the same cycle as `rx_valid`: the byte is not accepted.

## Timing
- `data_valid`/`data_out` are registered. They assert the cycle after the 3rd, 4th, … data byte is accepted.
- Full-rate throughput: one byte per cycle in DATA and DRAIN.
- `pkt_ok`/`pkt_err` are registered and high for exactly one cycle: the cycle after the edge that samples `rx_active`=0.
- `pkt_ok` and `pkt_err` are never high together.
- The first byte of the next packet can be accepted 2 cycles after `rx_active` is sampled low (the DONE cycle blocks).
- Reset mid-packet: `data_valid`, `pkt_ok`, `pkt_err` are 0 the cycle after reset. No partial verdict is issued.

## Configuration
- Macro `USB_RX_PID_CHECK_EN`.
- Defined: the PID check passes only when `rx_data[7:4] == ~rx_data[3:0]`.
- Undefined: every PID byte passes; only the CRC, length and overflow checks apply.

## Test plan
- Zero-length DATA0: bytes C3, 00, 00, then `rx_active` low. Required: `pkt_ok`=1 for one cycle, `pid`=3, `pkt_len`=0, no `data_valid`.
- Payload 01..04 + correct CRC from a model: `data_out` = 01, 02, 03, 04 on four strobes; `pkt_ok`; `pkt_len`=4.
- Same packet with the last CRC byte XOR 0x01: same 4 strobes; `pkt_err`=1, `pkt_ok`=0.
- PID byte 0xC4 with the macro defined: no strobes, DRAIN until `rx_active` low, then `pkt_err`. With the macro undefined, a valid CRC gives `pkt_ok`.
- MAX_LEN+3 payload+CRC bytes: switches to DRAIN on the overflowing byte; `pkt_err`.
- Reset low for one cycle mid-payload while `rx_active` stays high: no verdict. The next packet after `rx_active` low→high gives `pkt_ok`.
